// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard/forwarding controller.
package hazard_pkg;
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;
    localparam int unsigned REG_ZERO = 0;
endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: per-operand EX forwarding select; MEM beats WB, loads in MEM never forward.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic [REG_AW-1:0] rw_mem_i,
    input  logic              regwr_mem_i,
    input  logic              memtoreg_mem_i,
    input  logic [REG_AW-1:0] rw_wb_i,
    input  logic              regwr_wb_i,
    output fwd_sel_t          sel_o
);
    localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);
    logic hit_mem, hit_wb;
    assign hit_mem = regwr_mem_i && !memtoreg_mem_i && rw_mem_i != ZERO && rw_mem_i == src_i;
    assign hit_wb  = regwr_wb_i && rw_wb_i != ZERO && rw_wb_i == src_i;
    assign sel_o   = hit_mem ? FWD_MEM : hit_wb ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_ctrl_p.sv
// hazard_ctrl_p: stall/bubble/flush/forwarding control with multi-cycle MDU freeze.
// Optional stall-cycle counter (stall_cnt, perf_clr) enabled by HAZARD_PERF_EN.
module hazard_ctrl_p
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs_id,
    input  logic [REG_AW-1:0] rt_id,
    input  logic [REG_AW-1:0] rs_ex,
    input  logic [REG_AW-1:0] rt_ex,
    input  logic [REG_AW-1:0] rw_ex,
    input  logic [REG_AW-1:0] rw_mem,
    input  logic [REG_AW-1:0] rw_wb,
    input  logic              regwr_ex,
    input  logic              regwr_mem,
    input  logic              regwr_wb,
    input  logic              memtoreg_ex,
    input  logic              memtoreg_mem,
    input  logic              branch_id,
    input  logic              branch_taken,
    input  logic              mdu_start,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              id_ex_bubble,
    output logic              id_ex_hold,
    output logic              if_id_flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              mdu_busy
`ifdef HAZARD_PERF_EN
    ,
    input  logic              perf_clr,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);
    localparam int CW = $clog2(MDU_LAT);
    localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);

    mdu_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic hit_ex, hit_mem, haz, busy;
    fwd_sel_t sel_a, sel_b;

    assign hit_ex  = rw_ex != ZERO && (rw_ex == rs_id || rw_ex == rt_id);
    assign hit_mem = rw_mem != ZERO && (rw_mem == rs_id || rw_mem == rt_id);
    // A load in EX stalls any consumer; a branch also waits on ALU results in EX and loads in MEM.
    assign haz = (memtoreg_ex && hit_ex)
              || (branch_id && regwr_ex && !memtoreg_ex && hit_ex)
              || (branch_id && memtoreg_mem && hit_mem);
    assign busy = state_q == BUSY;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        if (state_q == IDLE) begin
            if (mdu_start) begin
                state_d = BUSY;
                cnt_d   = CW'(MDU_LAT - 2);
            end
        end else if (cnt_q == '0) begin
            state_d = IDLE;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
        // Outputs are forced low while reset is asserted, independent of inputs.
        pc_stall     = rst_n && (busy || haz);
        if_id_stall  = rst_n && (busy || haz);
        id_ex_bubble = rst_n && !busy && haz;
        id_ex_hold   = rst_n && busy;
        if_id_flush  = rst_n && !busy && !haz && branch_taken;
        mdu_busy     = rst_n && busy;
        fwd_a_sel    = rst_n ? sel_a : FWD_RF;
        fwd_b_sel    = rst_n ? sel_b : FWD_RF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .src_i(rs_ex), .rw_mem_i(rw_mem), .regwr_mem_i(regwr_mem), .memtoreg_mem_i(memtoreg_mem),
        .rw_wb_i(rw_wb), .regwr_wb_i(regwr_wb), .sel_o(sel_a)
    );
    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .src_i(rt_ex), .rw_mem_i(rw_mem), .regwr_mem_i(regwr_mem), .memtoreg_mem_i(memtoreg_mem),
        .rw_wb_i(rw_wb), .regwr_wb_i(regwr_wb), .sel_o(sel_b)
    );

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    assign stall_cnt_d = perf_clr ? '0
                       : (pc_stall && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1)
                       : stall_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else stall_cnt_q <= stall_cnt_d;
    end
    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl_p.sv
// tb_hazard_ctrl_p: directed self-checking bench for hazard_ctrl_p (MDU_LAT=4, CNT_W=4).
module tb_hazard_ctrl_p;
    logic       clk, rst_n;
    logic [4:0] rs_id, rt_id, rs_ex, rt_ex, rw_ex, rw_mem, rw_wb;
    logic       regwr_ex, regwr_mem, regwr_wb, memtoreg_ex, memtoreg_mem;
    logic       branch_id, branch_taken, mdu_start;
    logic       pc_stall, if_id_stall, id_ex_bubble, id_ex_hold, if_id_flush, mdu_busy;
    logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef HAZARD_PERF_EN
    logic       perf_clr;
    logic [3:0] stall_cnt;
`endif
    int n_chk = 0;
    int n_fail = 0;

    hazard_ctrl_p #(.REG_AW(5), .MDU_LAT(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_id(rs_id), .rt_id(rt_id), .rs_ex(rs_ex), .rt_ex(rt_ex),
        .rw_ex(rw_ex), .rw_mem(rw_mem), .rw_wb(rw_wb),
        .regwr_ex(regwr_ex), .regwr_mem(regwr_mem), .regwr_wb(regwr_wb),
        .memtoreg_ex(memtoreg_ex), .memtoreg_mem(memtoreg_mem),
        .branch_id(branch_id), .branch_taken(branch_taken), .mdu_start(mdu_start),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_bubble(id_ex_bubble),
        .id_ex_hold(id_ex_hold), .if_id_flush(if_id_flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .mdu_busy(mdu_busy)
`ifdef HAZARD_PERF_EN
        , .perf_clr(perf_clr), .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {pc_stall, if_id_stall, id_ex_bubble, id_ex_hold, if_id_flush, mdu_busy}
    task automatic chk_ctl(input string tag, input logic [5:0] exp);
        check(tag, {26'd0, pc_stall, if_id_stall, id_ex_bubble, id_ex_hold, if_id_flush, mdu_busy}, {26'd0, exp});
    endtask

    task automatic idle_in();
        {rs_id, rt_id, rs_ex, rt_ex, rw_ex, rw_mem, rw_wb} = '0;
        {regwr_ex, regwr_mem, regwr_wb, memtoreg_ex, memtoreg_mem} = '0;
        {branch_id, branch_taken, mdu_start} = '0;
`ifdef HAZARD_PERF_EN
        perf_clr = 1'b0;
`endif
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic load_use();
        memtoreg_ex = 1'b1; regwr_ex = 1'b1; rw_ex = 5'd5; rs_id = 5'd5;
    endtask

    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] STALL = 6'b111000;
    localparam logic [5:0] FREEZE = 6'b110101;
    localparam logic [5:0] FLUSH = 6'b000010;

    initial begin
        idle_in();
        rst_n = 1'b0;
        load_use();
        branch_taken = 1'b1; mdu_start = 1'b1;
        rs_ex = 5'd3; rw_mem = 5'd3; regwr_mem = 1'b1;
        repeat (2) next();
        look();
        chk_ctl("reset_ctl", NONE);
        check("reset_fwd_a", fwd_a_sel, 2'b00);
`ifdef HAZARD_PERF_EN
        check("reset_cnt", stall_cnt, 4'd0);
`endif
        idle_in();
        rst_n = 1'b1;
        next();

        load_use();
        look(); chk_ctl("load_use", STALL);
        next(); idle_in();
        look(); chk_ctl("load_use_done", NONE);
        memtoreg_ex = 1'b1; regwr_ex = 1'b1; rw_ex = 5'd0; rs_id = 5'd0;
        look(); chk_ctl("load_use_r0", NONE);
        next(); idle_in();
        memtoreg_ex = 1'b1; rw_ex = 5'd7; rt_id = 5'd7;
        look(); chk_ctl("load_use_rt", STALL);
        next(); idle_in();

        branch_id = 1'b1; rt_id = 5'd8; memtoreg_ex = 1'b1; regwr_ex = 1'b1; rw_ex = 5'd8;
        look(); chk_ctl("br_load_c1", STALL);
        next();
        memtoreg_ex = 1'b0; regwr_ex = 1'b0; rw_ex = 5'd0;
        rw_mem = 5'd8; memtoreg_mem = 1'b1; regwr_mem = 1'b1;
        look(); chk_ctl("br_load_c2", STALL);
        next();
        rw_mem = 5'd0; memtoreg_mem = 1'b0; regwr_mem = 1'b0;
        rw_wb = 5'd8; regwr_wb = 1'b1; branch_taken = 1'b1;
        look(); chk_ctl("br_flush", FLUSH);
        next(); idle_in();
        look(); chk_ctl("br_flush_done", NONE);

        branch_id = 1'b1; rs_id = 5'd6; rw_ex = 5'd6; regwr_ex = 1'b1;
        look(); chk_ctl("br_alu", STALL);
        regwr_ex = 1'b0; #1;
        chk_ctl("br_alu_nowr", NONE);
        branch_id = 1'b0; regwr_ex = 1'b1; #1;
        chk_ctl("alu_nobranch", NONE);
        next(); idle_in();

        rs_ex = 5'd3; rt_ex = 5'd3; rw_mem = 5'd3; regwr_mem = 1'b1; rw_wb = 5'd3; regwr_wb = 1'b1;
        look();
        check("fwd_a_mem", fwd_a_sel, 2'b01);
        check("fwd_b_mem", fwd_b_sel, 2'b01);
        regwr_mem = 1'b0; #1;
        check("fwd_a_wb", fwd_a_sel, 2'b10);
        regwr_mem = 1'b1; memtoreg_mem = 1'b1; #1;
        check("fwd_a_load_mem", fwd_a_sel, 2'b10);
        rs_ex = 5'd0; rt_ex = 5'd4; rw_mem = 5'd0; rw_wb = 5'd0; #1;
        check("fwd_a_r0", fwd_a_sel, 2'b00);
        check("fwd_b_none", fwd_b_sel, 2'b00);
        next(); idle_in();
        load_use(); rs_ex = 5'd3; rw_wb = 5'd3; regwr_wb = 1'b1;
        look();
        chk_ctl("fwd_stall_ctl", STALL);
        check("fwd_during_stall", fwd_a_sel, 2'b10);
        next(); idle_in();

        mdu_start = 1'b1;
        look(); chk_ctl("mdu_start_cyc", NONE);
        next(); mdu_start = 1'b0;
        look(); chk_ctl("mdu_b1", FREEZE);
        next(); branch_taken = 1'b1; mdu_start = 1'b1;
        look(); chk_ctl("mdu_b2_flush", FREEZE);
        next(); idle_in(); load_use();
        look(); chk_ctl("mdu_b3_haz", FREEZE);
        next(); idle_in();
        look(); chk_ctl("mdu_done", NONE);

        mdu_start = 1'b1;
        next(); mdu_start = 1'b0;
        look(); chk_ctl("rst_b1", FREEZE);
        next();
        branch_taken = 1'b1; rs_ex = 5'd3; rw_mem = 5'd3; regwr_mem = 1'b1;
        #1;
        check("rst_pre_fwd", fwd_a_sel, 2'b01);
        rst_n = 1'b0;
        #1;
        chk_ctl("rst_mid_busy", NONE);
        check("rst_mid_fwd", fwd_a_sel, 2'b00);
        look();
        idle_in();
        rst_n = 1'b1;
        next();
        look(); chk_ctl("rst_idle", NONE);
        mdu_start = 1'b1;
        next(); mdu_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            look(); chk_ctl($sformatf("rst_fresh_b%0d", i + 1), FREEZE);
            next();
        end
        look(); chk_ctl("rst_fresh_done", NONE);

`ifdef HAZARD_PERF_EN
        perf_clr = 1'b1; load_use();
        next(); idle_in();
        look(); check("perf_clr_prio", stall_cnt, 4'd0);
        for (int i = 0; i < 2; i++) begin
            load_use(); next(); idle_in(); next();
        end
        mdu_start = 1'b1; next(); mdu_start = 1'b0;
        repeat (3) next();
        look(); check("perf_cnt5", stall_cnt, 4'd5);
        perf_clr = 1'b1; next(); perf_clr = 1'b0;
        look(); check("perf_clr", stall_cnt, 4'd0);
        for (int i = 0; i < 14; i++) begin
            load_use(); next();
        end
        idle_in();
        look(); check("perf_cnt14", stall_cnt, 4'd14);
        mdu_start = 1'b1; next(); mdu_start = 1'b0;
        repeat (3) next();
        look(); check("perf_sat", stall_cnt, 4'd15);
        load_use(); next(); idle_in();
        look(); check("perf_sat_hold", stall_cnt, 4'd15);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl_p.md
Name: hazard_ctrl_p

Overview:
Parametrised hazard and forwarding controller for the 5-stage pipeline (IF/ID/EX/MEM/WB); successor to the single-rule stall unit.
- Detects load-use and branch-operand hazards; generates PC/IF_ID stall and ID_EX bubble.
- Selects EX-stage forwarding sources; flushes IF_ID on a taken branch.
- Freezes the front end for a configurable multi-cycle multiply/divide latency using an internal FSM and counter.

Parameters:
- REG_AW, 5, register-address width.
- MDU_LAT, 4, EX occupancy of a multi-cycle op in cycles (>=2).
- CNT_W, 16, width of the optional stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rs_id, rt_id  in  REG_AW  source registers of the instruction in ID.
- rs_ex, rt_ex  in  REG_AW  source registers of the instruction in EX.
- rw_ex, rw_mem, rw_wb  in  REG_AW  destination register per stage.
- regwr_ex, regwr_mem, regwr_wb  in  1  register write enable per stage.
- memtoreg_ex, memtoreg_mem  in  1  load in EX / MEM.
- branch_id  in  1  branch in ID.
- branch_taken  in  1  ID branch resolves taken (valid only when not stalled).
- mdu_start  in  1  EX holds a multi-cycle op this cycle.
- pc_stall, if_id_stall  out  1  hold PC / IF_ID.
- id_ex_bubble  out  1  load NOP into ID_EX.
- id_ex_hold  out  1  hold ID_EX contents.
- if_id_flush  out  1  clear IF_ID.
- fwd_a_sel, fwd_b_sel  out  2  EX operand source: 00 regfile, 01 MEM, 10 WB.
- mdu_busy  out  1  FSM is in BUSY.

Behaviour:
- Register 0 never creates a hazard or a forward; every match requires a non-zero destination.
- Load-use: memtoreg_ex and rw_ex matches rs_id or rt_id -> 1 stall cycle.
- Branch, ALU producer in EX: branch_id, regwr_ex, not memtoreg_ex, and rw_ex matches a branch source -> 1 stall cycle.
- Branch, load in EX: branch_id, memtoreg_ex, and a match -> stall. This repeats naturally, giving 2 cycles total.
- Branch, load in MEM: branch_id, memtoreg_mem, and rw_mem matches a branch source -> 1 stall cycle.
- Stall (haz=1): pc_stall=if_id_stall=id_ex_bubble=1, id_ex_hold=0.
- Forwarding, per operand:
  - MEM has priority: regwr_mem, not memtoreg_mem, and rw_mem==src -> 01.
  - Else WB: regwr_wb and rw_wb==src -> 10.
  - Else 00.
  - Forwarding is purely combinational and independent of the stall logic.
- MDU FSM:
  - States: IDLE, BUSY.
  - IDLE to BUSY on mdu_start; cnt loads MDU_LAT-2.
  - In BUSY, cnt decrements each cycle; BUSY to IDLE when cnt==0.
  - Total front-end freeze is exactly MDU_LAT-1 cycles after the start cycle.
  - In BUSY: pc_stall=if_id_stall=id_ex_hold=1, id_ex_bubble=0, if_id_flush=0.
  - mdu_start while BUSY is ignored.
- Priority: BUSY > haz stall > flush.
- if_id_flush=branch_taken, only when not BUSY and haz=0.
- All outputs are combinational from state and inputs.
- Reset: FSM=IDLE, cnt=0; all stall/flush/fwd/busy outputs are 0 while rst_n=0, regardless of inputs.
- Reset mid-BUSY: return to IDLE immediately; outputs drop asynchronously.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined:
  - Adds ports stall_cnt out CNT_W and perf_clr in 1.
  - stall_cnt increments on each cycle where pc_stall=1.
  - Saturates at all-ones (no wrap).
  - perf_clr is a synchronous clear with priority over increment.
  - Reset value 0.
- When undefined: neither port exists, and no counter logic is present.

Decomposition:
- Package hazard_pkg:
  - Typedef fwd_sel_t (2-bit enum: FWD_RF, FWD_MEM, FWD_WB).
  - Typedef mdu_state_t (IDLE, BUSY).
  - Constant REG_ZERO.
- One natural sub-module: hazard_fwd_sel, the combinational per-operand forwarding mux select, instantiated twice (operands A and B).

Test Plan:
- Load-use: memtoreg_ex=1, rw_ex=5, rs_id=5 -> pc_stall=if_id_stall=id_ex_bubble=1 for one cycle. Repeat with rw_ex=0 -> no stall.
- Branch after load: branch_id=1, rt_id=8, memtoreg_ex=1, rw_ex=8; next cycle load advances to rw_mem=8, memtoreg_mem=1 -> stall for exactly 2 consecutive cycles, then branch_taken=1 -> if_id_flush=1 for one cycle.
- Forward priority: rs_ex=3, rw_mem=3, regwr_mem=1, rw_wb=3, regwr_wb=1 -> fwd_a_sel=01. Drop regwr_mem -> fwd_a_sel=10.
- MDU (MDU_LAT=4): mdu_start pulse -> mdu_busy/id_ex_hold/pc_stall high for exactly 3 cycles. branch_taken asserted in that window -> if_id_flush=0.
- Reset: assert rst_n=0 in 2nd BUSY cycle -> all outputs 0 immediately. After release, FSM is IDLE and a fresh mdu_start gives the full 3-cycle freeze.
- HAZARD_PERF_EN: 2 load-use stalls + one MDU op -> stall_cnt=5. perf_clr -> 0 next edge. Preload near max (CNT_W=4, 14 stalls + 3) -> saturates at 15.
